writeback_unit: RTL

Write-side initiator for the core's 32-entry register file. Accepts result writes from the ALU and the load/store unit (LSU) over valid/ready handshakes and buffers them in a small in-order queue. Drains one entry per cycle onto the register file write port (`rd_addr`/`rd_data`/`reg_write_enable`). Also provides a forwarding lookup so operand fetch sees results not yet committed to the register file.

---
 rtl/core_pkg.sv | 12 +
 rtl/wb_fifo.sv | 70 +++++++
 rtl/writeback_unit.sv | 135 +++++++++++++
 3 files changed

// File: rtl/core_pkg.sv
// Shared core types: data width, register address width and the writeback entry.
package core_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned REG_ADDR_W = 5;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// In-order circular queue of writeback entries with two write ports (A older than B)
// and one read port; exposes occupancy and per-slot contents for forwarding.
module wb_fifo
  import core_pkg::*;
#(
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push_a,
  input  wb_entry_t        i_entry_a,
  input  logic             i_push_b,
  input  wb_entry_t        i_entry_b,
  input  logic             i_pop,
  output logic [CNT_W-1:0] o_count,
  output logic [PTR_W-1:0] o_head_ptr,
  output wb_entry_t        o_head,
  output logic [DEPTH-1:0] o_valid,
  output wb_entry_t        o_entries [DEPTH]
);

  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [CNT_W-1:0] r_count;
  wb_entry_t        r_mem [DEPTH];

  logic [CNT_W-1:0] w_npush;
  logic [PTR_W-1:0] w_slot_b;

  assign w_npush  = CNT_W'(i_push_a) + CNT_W'(i_push_b);
  assign w_slot_b = i_push_a ? (r_tail + PTR_W'(1)) : r_tail;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      r_tail  <= r_tail + PTR_W'(w_npush);
      r_head  <= r_head + PTR_W'(i_pop);
      r_count <= r_count + w_npush - CNT_W'(i_pop);
    end
  end

  // Storage needs no reset: slots are only observed through o_valid.
  always_ff @(posedge clk) begin
    if (i_push_a) r_mem[r_tail]   <= i_entry_a;
    if (i_push_b) r_mem[w_slot_b] <= i_entry_b;
  end

  function automatic logic [PTR_W-1:0] slot_age(input logic [PTR_W-1:0] slot,
                                                input logic [PTR_W-1:0] head);
    return slot - head;
  endfunction

  always_comb begin
    o_valid = '0;
    for (int i = 0; i < DEPTH; i++) begin
      o_valid[i] = CNT_W'(slot_age(PTR_W'(i), r_head)) < r_count;
    end
  end

  assign o_count    = r_count;
  assign o_head_ptr = r_head;
  assign o_head     = r_mem[r_head];
  assign o_entries  = r_mem;

endmodule

// File: rtl/writeback_unit.sv
// Register-file write initiator: arbitrates ALU/LSU results into an in-order queue,
// retires one entry per cycle through a registered output stage, and forwards pending values.
module writeback_unit
  import core_pkg::wb_entry_t;
  import core_pkg::REG_ADDR_W;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned XLEN  = core_pkg::XLEN
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  alu_valid,
  output logic                  alu_ready,
  input  logic [REG_ADDR_W-1:0] alu_rd,
  input  logic [XLEN-1:0]       alu_data,
  input  logic                  lsu_valid,
  output logic                  lsu_ready,
  input  logic [REG_ADDR_W-1:0] lsu_rd,
  input  logic [XLEN-1:0]       lsu_data,
  output logic [REG_ADDR_W-1:0] rd_addr,
  output logic [XLEN-1:0]       rd_data,
  output logic                  reg_write_enable,
  input  logic [REG_ADDR_W-1:0] rs1_addr,
  input  logic [REG_ADDR_W-1:0] rs2_addr,
  output logic                  rs1_fwd_hit,
  output logic                  rs2_fwd_hit,
  output logic [XLEN-1:0]       rs1_fwd_data,
  output logic [XLEN-1:0]       rs2_fwd_data,
  output logic                  empty
);

  localparam int unsigned PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W   = $clog2(DEPTH + 1);
  localparam int unsigned ENTRY_W = core_pkg::XLEN;

  logic [CNT_W-1:0]      w_count;
  logic [CNT_W-1:0]      w_free;
  logic [PTR_W-1:0]      w_head_ptr;
  wb_entry_t             w_head;
  logic [DEPTH-1:0]      w_valid;
  wb_entry_t             w_entries [DEPTH];
  wb_entry_t             w_entry_a;
  wb_entry_t             w_entry_b;
  logic                  w_push_a;
  logic                  w_push_b;
  logic                  w_pop;

  logic                  r_we;
  logic [REG_ADDR_W-1:0] r_rd;
  logic [XLEN-1:0]       r_data;

  // Readiness looks only at registered occupancy; a same-cycle drain is not credited.
  assign w_free    = CNT_W'(DEPTH) - w_count;
  assign alu_ready = (w_free != '0);
  assign lsu_ready = (w_free >= CNT_W'(2)) || ((w_free != '0) && !alu_valid);

  // x0 results are consumed by the handshake but never stored.
  assign w_push_a  = alu_valid && alu_ready && (alu_rd != '0);
  assign w_push_b  = lsu_valid && lsu_ready && (lsu_rd != '0);
  assign w_pop     = (w_count != '0);

  assign w_entry_a = '{rd: alu_rd, data: ENTRY_W'(alu_data)};
  assign w_entry_b = '{rd: lsu_rd, data: ENTRY_W'(lsu_data)};

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_push_a   (w_push_a),
    .i_entry_a  (w_entry_a),
    .i_push_b   (w_push_b),
    .i_entry_b  (w_entry_b),
    .i_pop      (w_pop),
    .o_count    (w_count),
    .o_head_ptr (w_head_ptr),
    .o_head     (w_head),
    .o_valid    (w_valid),
    .o_entries  (w_entries)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_we   <= 1'b0;
      r_rd   <= '0;
      r_data <= '0;
    end else begin
      r_we <= w_pop;
      if (w_pop) begin
        r_rd   <= w_head.rd;
        r_data <= XLEN'(w_head.data);
      end
    end
  end

  assign reg_write_enable = r_we;
  assign rd_addr          = r_rd;
  assign rd_data          = r_data;
  assign empty            = (w_count == '0) && !r_we;

  logic [REG_ADDR_W-1:0] w_rs       [2];
  logic [1:0]            w_fwd_hit;
  logic [XLEN-1:0]       w_fwd_data [2];
  logic [PTR_W-1:0]      w_idx;

  assign w_rs[0] = rs1_addr;
  assign w_rs[1] = rs2_addr;

  // Oldest first (output stage, then head..tail) so the youngest match is written last.
  always_comb begin
    w_fwd_hit     = '0;
    w_fwd_data[0] = '0;
    w_fwd_data[1] = '0;
    w_idx         = '0;
    for (int p = 0; p < 2; p++) begin
      if (w_rs[p] != '0) begin
        if (r_we && (r_rd == w_rs[p])) begin
          w_fwd_hit[p]  = 1'b1;
          w_fwd_data[p] = r_data;
        end
        for (int k = 0; k < DEPTH; k++) begin
          w_idx = w_head_ptr + PTR_W'(k);
          if (w_valid[w_idx] && (w_entries[w_idx].rd == w_rs[p])) begin
            w_fwd_hit[p]  = 1'b1;
            w_fwd_data[p] = XLEN'(w_entries[w_idx].data);
          end
        end
      end
    end
  end

  assign rs1_fwd_hit  = w_fwd_hit[0];
  assign rs2_fwd_hit  = w_fwd_hit[1];
  assign rs1_fwd_data = w_fwd_data[0];
  assign rs2_fwd_data = w_fwd_data[1];

endmodule
